// File: rtl/mc_pkg.sv
// Shared memory-controller definitions: write-data FIFO geometry and entry layout.
package mc_pkg;
    localparam int WDF_DEPTH = 8;
    localparam int WDF_PTR_W = 3;
    localparam int MC_DATA_W = 64;

    typedef struct packed {
        logic [MC_DATA_W-1:0] data;
        logic                 p;
    } wdf_entry_t;
endpackage

// File: rtl/wdf_ffs.sv
// Find-first-free priority encoder: lowest index whose valid bit is clear.
module wdf_ffs
    import mc_pkg::*;
(
    input  logic [WDF_DEPTH-1:0] valid,
    output logic                 vld,
    output logic [WDF_PTR_W-1:0] ptr
);

    // Scan from the top down so the last hit, the lowest free index, wins.
    always_comb begin
        vld = 1'b0;
        ptr = '0;
        for (int i = WDF_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                vld = 1'b1;
                ptr = WDF_PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/wdf.sv
// Write-data FIFO: 8 TL-allocated entries written by index, read-and-released by the scheduler.
module wdf
    import mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tlxr_wdf_wr,
    input  logic                 tlxr_wdf_wr_p,
    input  logic [WDF_PTR_W-1:0] tlxr_wdf_ptr,
    input  logic [MC_DATA_W-1:0] tlxr_wdf_data,
    output logic                 wdf_free_vld,
    output logic [WDF_PTR_W-1:0] wdf_free_ptr,
    output logic [3:0]           wdf_cnt,
    input  logic                 sch_wdf_rd,
    input  logic [WDF_PTR_W-1:0] sch_wdf_ptr,
    output logic                 wdf_rd_vld,
    output logic [MC_DATA_W-1:0] wdf_rd_data,
    output logic                 wdf_rd_p,
    output logic                 wdf_err
);

    wdf_entry_t           mem [WDF_DEPTH];
    logic [WDF_DEPTH-1:0] valid;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 wr_bad;
    logic                 rd_bad;

    // All acceptance decisions use the valid bits from the start of the cycle,
    // so a same-entry write+read sees the entry as occupied: read wins, write errors.
    always_comb begin
        wr_ok  = tlxr_wdf_wr &  ~valid[tlxr_wdf_ptr];
        wr_bad = tlxr_wdf_wr &   valid[tlxr_wdf_ptr];
        rd_ok  = sch_wdf_rd  &   valid[sch_wdf_ptr];
        rd_bad = sch_wdf_rd  &  ~valid[sch_wdf_ptr];
    end

    // NOTE: the data array has no reset; only the valid bits say whether an entry means anything.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[tlxr_wdf_ptr] <= '{data: tlxr_wdf_data, p: tlxr_wdf_wr_p};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            wdf_cnt     <= '0;
            wdf_rd_vld  <= 1'b0;
            wdf_rd_data <= '0;
            wdf_rd_p    <= 1'b0;
            wdf_err     <= 1'b0;
        end else begin
            valid <= (valid | ({{(WDF_DEPTH-1){1'b0}}, wr_ok} << tlxr_wdf_ptr))
                   & ~({{(WDF_DEPTH-1){1'b0}}, rd_ok} << sch_wdf_ptr);

            case ({wr_ok, rd_ok})
                2'b10:   wdf_cnt <= wdf_cnt + 4'd1;
                2'b01:   wdf_cnt <= wdf_cnt - 4'd1;
                default: wdf_cnt <= wdf_cnt;
            endcase

            wdf_rd_vld <= rd_ok;
            if (rd_ok) begin
                wdf_rd_data <= mem[sch_wdf_ptr].data;
                wdf_rd_p    <= mem[sch_wdf_ptr].p;
            end

            if (wr_bad || rd_bad) begin
                wdf_err <= 1'b1;
            end
        end
    end

    wdf_ffs u_ffs (
        .valid (valid),
        .vld   (wdf_free_vld),
        .ptr   (wdf_free_ptr)
    );

endmodule

// File: tb/tb_wdf.sv
// Directed, table-driven bench for the write-data FIFO plus hand-written reset/error sequences.
module tb_wdf;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        tlxr_wdf_wr;
    logic        tlxr_wdf_wr_p;
    logic [2:0]  tlxr_wdf_ptr;
    logic [63:0] tlxr_wdf_data;
    logic        wdf_free_vld;
    logic [2:0]  wdf_free_ptr;
    logic [3:0]  wdf_cnt;
    logic        sch_wdf_rd;
    logic [2:0]  sch_wdf_ptr;
    logic        wdf_rd_vld;
    logic [63:0] wdf_rd_data;
    logic        wdf_rd_p;
    logic        wdf_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wdf dut (
        .clk           (clk),
        .rst           (rst),
        .tlxr_wdf_wr   (tlxr_wdf_wr),
        .tlxr_wdf_wr_p (tlxr_wdf_wr_p),
        .tlxr_wdf_ptr  (tlxr_wdf_ptr),
        .tlxr_wdf_data (tlxr_wdf_data),
        .wdf_free_vld  (wdf_free_vld),
        .wdf_free_ptr  (wdf_free_ptr),
        .wdf_cnt       (wdf_cnt),
        .sch_wdf_rd    (sch_wdf_rd),
        .sch_wdf_ptr   (sch_wdf_ptr),
        .wdf_rd_vld    (wdf_rd_vld),
        .wdf_rd_data   (wdf_rd_data),
        .wdf_rd_p      (wdf_rd_p),
        .wdf_err       (wdf_err)
    );

    typedef struct {
        logic        wr;
        logic        wr_p;
        logic [2:0]  wptr;
        logic [63:0] wdata;
        logic        rd;
        logic [2:0]  rptr;
        logic        e_rd_vld;
        logic [63:0] e_rd_data;
        logic        e_rd_p;
        logic [3:0]  e_cnt;
        logic        e_free_vld;
        logic [2:0]  e_free_ptr;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic wr_p, input logic [2:0] wptr,
                                input logic [63:0] wdata, input logic rd, input logic [2:0] rptr,
                                input logic e_rd_vld, input logic [63:0] e_rd_data, input logic e_rd_p,
                                input logic [3:0] e_cnt, input logic e_free_vld,
                                input logic [2:0] e_free_ptr, input logic e_err);
        vec_t v;
        v.wr = wr;  v.wr_p = wr_p;  v.wptr = wptr;  v.wdata = wdata;
        v.rd = rd;  v.rptr = rptr;
        v.e_rd_vld = e_rd_vld;  v.e_rd_data = e_rd_data;  v.e_rd_p = e_rd_p;
        v.e_cnt = e_cnt;  v.e_free_vld = e_free_vld;  v.e_free_ptr = e_free_ptr;  v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_rd_vld, input logic [63:0] e_rd_data,
                             input logic e_rd_p, input logic [3:0] e_cnt, input logic e_free_vld,
                             input logic [2:0] e_free_ptr, input logic e_err);
        check({tag, ".rd_vld"},   64'(wdf_rd_vld),   64'(e_rd_vld));
        check({tag, ".rd_data"},  wdf_rd_data,       e_rd_data);
        check({tag, ".rd_p"},     64'(wdf_rd_p),     64'(e_rd_p));
        check({tag, ".cnt"},      64'(wdf_cnt),      64'(e_cnt));
        check({tag, ".free_vld"}, 64'(wdf_free_vld), 64'(e_free_vld));
        check({tag, ".free_ptr"}, 64'(wdf_free_ptr), 64'(e_free_ptr));
        check({tag, ".err"},      64'(wdf_err),      64'(e_err));
    endtask

    task automatic drive(input logic wr, input logic wr_p, input logic [2:0] wptr,
                         input logic [63:0] wdata, input logic rd, input logic [2:0] rptr);
        tlxr_wdf_wr   = wr;
        tlxr_wdf_wr_p = wr_p;
        tlxr_wdf_ptr  = wptr;
        tlxr_wdf_data = wdata;
        sch_wdf_rd    = rd;
        sch_wdf_ptr   = rptr;
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0);
        tick();
        tick();
        check_all("reset", 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 3'd0, 1'b0);
        rst = 1'b0;

        // Basic write, read, and hold of read data.
        add(1, 0, 2, 64'hFF, 0, 0,   0, 64'h0,  0, 1, 1, 0, 0);
        add(0, 0, 0, 64'h0,  1, 2,   1, 64'hFF, 0, 0, 1, 0, 0);
        add(0, 0, 0, 64'h0,  0, 0,   0, 64'hFF, 0, 0, 1, 0, 0);
        // Fill all eight entries.
        for (int i = 0; i < 8; i++) begin
            add(1, 1'(i & 1), 3'(i), 64'h100 + 64'(i), 0, 0,
                0, 64'hFF, 0, 4'(i + 1), (i != 7), (i == 7) ? 3'd0 : 3'(i + 1), 0);
        end
        add(0, 0, 0, 64'h0, 1, 3,      1, 64'h103, 1, 7, 1, 3, 0);
        // Write to the freed entry while reading another one.
        add(1, 0, 3, 64'h203, 1, 0,    1, 64'h100, 0, 7, 1, 0, 0);
        for (int j = 1; j < 8; j++) begin
            add(0, 0, 0, 64'h0, 1, 3'(j),
                1, (j == 3) ? 64'h203 : 64'h100 + 64'(j), (j == 3) ? 1'b0 : 1'(j & 1),
                4'(7 - j), 1, 0, 0);
        end
        add(1, 0, 0, 64'h55, 0, 0,   0, 64'h107, 1, 1, 1, 1, 0);
        add(1, 1, 1, 64'h77, 1, 0,   1, 64'h55,  0, 1, 1, 0, 0);
        add(0, 0, 0, 64'h0,  1, 1,   1, 64'h77,  1, 0, 1, 0, 0);
        // Overwrite of a valid entry is dropped and flagged.
        add(1, 0, 5, 64'hA,  0, 0,   0, 64'h77,  1, 1, 1, 0, 0);
        add(1, 1, 5, 64'hB,  0, 0,   0, 64'h77,  1, 1, 1, 0, 1);
        add(0, 0, 0, 64'h0,  1, 5,   1, 64'hA,   0, 0, 1, 0, 1);
        add(0, 0, 0, 64'h0,  0, 0,   0, 64'hA,   0, 0, 1, 0, 1);

        foreach (vecs[k]) begin
            drive(vecs[k].wr, vecs[k].wr_p, vecs[k].wptr, vecs[k].wdata, vecs[k].rd, vecs[k].rptr);
            tick();
            check_all($sformatf("vec%0d", k), vecs[k].e_rd_vld, vecs[k].e_rd_data, vecs[k].e_rd_p,
                      vecs[k].e_cnt, vecs[k].e_free_vld, vecs[k].e_free_ptr, vecs[k].e_err);
        end

        // Reset clears error and read registers.
        do_reset();
        check_all("rst1", 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 3'd0, 1'b0);

        // Same-entry write and read: read returns old data, write dropped.
        drive(1'b1, 1'b0, 3'd4, 64'h11, 1'b0, 3'd0);
        tick();
        check_all("e4_wr", 1'b0, 64'd0, 1'b0, 4'd1, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 1'b1, 3'd4, 64'h22, 1'b1, 3'd4);
        tick();
        check_all("e4_collide", 1'b1, 64'h11, 1'b0, 4'd0, 1'b1, 3'd0, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 3'd4);
        tick();
        check_all("e4_reread", 1'b0, 64'h11, 1'b0, 4'd0, 1'b1, 3'd0, 1'b1);

        // Read of an empty entry.
        do_reset();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 3'd6);
        tick();
        check_all("rd_empty", 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 3'd0, 1'b1);

        // Reset with entries valid, overriding a same-cycle write and read.
        drive(1'b1, 1'b0, 3'd0, 64'h31, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b1, 3'd1, 64'h32, 1'b0, 3'd0);
        tick();
        check_all("pre_rst", 1'b0, 64'd0, 1'b0, 4'd2, 1'b1, 3'd2, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 64'h33, 1'b1, 3'd0);
        tick();
        check_all("mid_rst", 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 3'd0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 3'd1);
        tick();
        check_all("post_rst", 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 3'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
